// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_pkg
// Description : Constants and FSM state type shared by the branch resolve unit
//               and the IF-stage prediction table.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam logic [6:0] BRANCH_OPC = 7'b1100011;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } brs_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_if
// Description : IF/ID prediction, resolution and table-update signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
);
    logic             stall_i;
    logic             if_valid_i;
    logic [XLEN-1:0]  if_pc_i;
    logic             pred_taken_i;
    logic [XLEN-1:0]  pred_target_i;
    logic [31:0]      id_inst_i;
    logic             act_taken_i;
    logic [XLEN-1:0]  act_target_i;
    logic             flush_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             upd_valid_o;
    logic             upd_correct_o;
    logic [XLEN-1:0]  upd_target_o;
    logic [CNT_W-1:0] br_count_o;
    logic [CNT_W-1:0] mp_count_o;

    // Pipeline side drives the stage inputs and consumes the results.
    modport master (
        output stall_i, if_valid_i, if_pc_i, pred_taken_i, pred_target_i,
               id_inst_i, act_taken_i, act_target_i,
        input  flush_o, redirect_pc_o, upd_valid_o, upd_correct_o,
               upd_target_o, br_count_o, mp_count_o
    );

    modport slave (
        input  stall_i, if_valid_i, if_pc_i, pred_taken_i, pred_target_i,
               id_inst_i, act_taken_i, act_target_i,
        output flush_o, redirect_pc_o, upd_valid_o, upd_correct_o,
               upd_target_o, br_count_o, mp_count_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             arst_n,
    input  wire logic             i_inc,
    input  wire logic             i_clear,
    output logic      [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : ID-stage check of IF predictions; flush/redirect, table update
//               strobe and saturating branch/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  wire logic          clk,
    input  wire logic          arst_n,
    branch_resolve_unit_if.slave bus
);
    localparam logic [0:0] c_ST_RUN     = RUN;
    localparam logic [0:0] c_ST_RECOVER = RECOVER;

    logic [XLEN-1:0] r_pc;
    logic            r_ptaken;
    logic [XLEN-1:0] r_ptarget;
    logic            r_valid;
    logic [0:0]      r_state;

    logic            w_is_branch;
    logic            w_active;
    logic            w_resolve;
    logic            w_stale;
    logic            w_correct;
    logic            w_flush;
    logic [XLEN-1:0] w_fallthru;
    logic            w_unused_inst;

    assign w_is_branch   = (bus.id_inst_i[6:0] == BRANCH_OPC);
    assign w_unused_inst = ^bus.id_inst_i[31:7];
    assign w_active      = r_valid && !bus.stall_i && (r_state == c_ST_RUN);
    assign w_resolve     = w_active && w_is_branch;
    // A predicted-taken non-branch means the table hit on a stale entry.
    assign w_stale       = w_active && !w_is_branch && r_ptaken;
    assign w_correct     = (r_ptaken == bus.act_taken_i) &&
                           (!bus.act_taken_i || (r_ptarget == bus.act_target_i));
    assign w_flush       = (w_resolve && !w_correct) || w_stale;
    assign w_fallthru    = r_pc + XLEN'(4);

    assign bus.flush_o       = w_flush;
    assign bus.redirect_pc_o = !w_flush ? '0 :
                               (w_resolve && bus.act_taken_i) ? bus.act_target_i :
                               w_fallthru;
    assign bus.upd_valid_o   = w_resolve;
    assign bus.upd_correct_o = w_resolve && w_correct;
    assign bus.upd_target_o  = w_resolve ? bus.act_target_i : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_pc      <= '0;
            r_ptaken  <= 1'b0;
            r_ptarget <= '0;
            r_valid   <= 1'b0;
        end else if (!bus.stall_i) begin
            r_pc      <= bus.if_pc_i;
            r_ptaken  <= bus.pred_taken_i;
            r_ptarget <= bus.pred_target_i;
            r_valid   <= bus.if_valid_i && !w_flush;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_RUN:     if (w_flush) r_state <= c_ST_RECOVER;
                c_ST_RECOVER: if (!bus.stall_i) r_state <= c_ST_RUN;
                default:      r_state <= c_ST_RUN;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_br_cnt (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_inc   (w_resolve),
        .i_clear (1'b0),
        .o_count (bus.br_count_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mp_cnt (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_inc   (w_flush),
        .i_clear (1'b0),
        .o_count (bus.mp_count_o)
    );
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;
    localparam int c_XLEN  = 64;
    localparam int c_CNT_W = 2;
    localparam logic [31:0] c_BEQ = 32'h0000_0063;
    localparam logic [31:0] c_ADD = 32'h0000_0033;

    logic clk;
    logic arst_n;
    int   n_tests;
    int   n_fail;

    branch_resolve_unit_if #(.XLEN(c_XLEN), .CNT_W(c_CNT_W)) bus ();

    branch_resolve_unit #(.XLEN(c_XLEN), .CNT_W(c_CNT_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_if(input logic v, input logic [63:0] pc, input logic tk, input logic [63:0] tg);
        bus.if_valid_i    = v;
        bus.if_pc_i       = pc;
        bus.pred_taken_i  = tk;
        bus.pred_target_i = tg;
    endtask

    task automatic drive_id(input logic [31:0] inst, input logic tk, input logic [63:0] tg);
        bus.id_inst_i    = inst;
        bus.act_taken_i  = tk;
        bus.act_target_i = tg;
    endtask

    task automatic check_counts(input string tag, input int br, input int mp);
        check_val({tag, "_br"}, 64'(bus.br_count_o), 64'(br));
        check_val({tag, "_mp"}, 64'(bus.mp_count_o), 64'(mp));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        arst_n  = 1'b0;
        bus.stall_i = 1'b0;
        drive_if(1'b0, 64'h0, 1'b0, 64'h0);
        drive_id(c_ADD, 1'b0, 64'h0);

        // Reset state
        tick();
        tick();
        check_val("rst_flush",    64'(bus.flush_o),       64'h0);
        check_val("rst_redirect", bus.redirect_pc_o,      64'h0);
        check_val("rst_updv",     64'(bus.upd_valid_o),   64'h0);
        check_val("rst_updc",     64'(bus.upd_correct_o), 64'h0);
        check_val("rst_updt",     bus.upd_target_o,       64'h0);
        check_counts("rst", 0, 0);
        arst_n = 1'b1;

        // Correct taken prediction
        drive_if(1'b1, 64'h100, 1'b1, 64'h140);
        #1 check_val("t1_idle_flush", 64'(bus.flush_o), 64'h0);
        tick();
        drive_if(1'b0, 64'h0, 1'b0, 64'h0);
        drive_id(c_BEQ, 1'b1, 64'h140);
        #1;
        check_val("t1_updv",  64'(bus.upd_valid_o),   64'h1);
        check_val("t1_updc",  64'(bus.upd_correct_o), 64'h1);
        check_val("t1_flush", 64'(bus.flush_o),       64'h0);
        check_val("t1_updt",  bus.upd_target_o,       64'h140);
        check_val("t1_redir", bus.redirect_pc_o,      64'h0);
        tick();
        check_counts("t1", 1, 0);

        // Mispredict held by stall for three cycles
        drive_if(1'b1, 64'h500, 1'b0, 64'h0);
        drive_id(c_ADD, 1'b0, 64'h0);
        tick();
        drive_if(1'b0, 64'h0, 1'b0, 64'h0);
        drive_id(c_BEQ, 1'b1, 64'h540);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_val("st_hold_flush", 64'(bus.flush_o), 64'h0);
            tick();
        end
        check_counts("st_hold", 1, 0);
        bus.stall_i = 1'b0;
        #1;
        check_val("st_flush", 64'(bus.flush_o),  64'h1);
        check_val("st_redir", bus.redirect_pc_o, 64'h540);
        tick();
        check_counts("st", 2, 1);
        drive_id(c_ADD, 1'b0, 64'h0);
        #1 check_val("st_recover_flush", 64'(bus.flush_o), 64'h0);
        tick();

        // Stale table hit on a non-branch
        drive_if(1'b1, 64'h400, 1'b1, 64'h480);
        tick();
        drive_if(1'b0, 64'h0, 1'b0, 64'h0);
        drive_id(c_ADD, 1'b0, 64'h0);
        #1;
        check_val("stale_flush", 64'(bus.flush_o),     64'h1);
        check_val("stale_redir", bus.redirect_pc_o,    64'h404);
        check_val("stale_updv",  64'(bus.upd_valid_o), 64'h0);
        check_val("stale_updt",  bus.upd_target_o,     64'h0);
        tick();
        check_counts("stale", 2, 2);
        tick();

        // Wrong direction, with a wrong-path instruction in IF
        drive_if(1'b1, 64'h200, 1'b0, 64'h0);
        tick();
        drive_if(1'b1, 64'h204, 1'b1, 64'h500);
        drive_id(c_BEQ, 1'b1, 64'h180);
        #1;
        check_val("t2_flush", 64'(bus.flush_o),       64'h1);
        check_val("t2_redir", bus.redirect_pc_o,      64'h180);
        check_val("t2_updc",  64'(bus.upd_correct_o), 64'h0);
        check_val("t2_updv",  64'(bus.upd_valid_o),   64'h1);
        tick();
        check_counts("t2", 3, 3);
        drive_if(1'b0, 64'h0, 1'b0, 64'h0);
        drive_id(c_BEQ, 1'b0, 64'h0);
        #1;
        check_val("t2_recover_flush", 64'(bus.flush_o),     64'h0);
        check_val("t2_recover_updv",  64'(bus.upd_valid_o), 64'h0);
        tick();

        // Wrong target; counters already at their ceiling
        drive_if(1'b1, 64'h300, 1'b1, 64'h300);
        drive_id(c_ADD, 1'b0, 64'h0);
        tick();
        drive_if(1'b0, 64'h0, 1'b0, 64'h0);
        drive_id(c_BEQ, 1'b1, 64'h320);
        #1;
        check_val("t3_flush", 64'(bus.flush_o),       64'h1);
        check_val("t3_redir", bus.redirect_pc_o,      64'h320);
        check_val("t3_updt",  bus.upd_target_o,       64'h320);
        check_val("t3_updc",  64'(bus.upd_correct_o), 64'h0);
        tick();
        check_counts("t3_sat", 3, 3);
        drive_id(c_ADD, 1'b0, 64'h0);
        tick();

        // Correct not-taken
        drive_if(1'b1, 64'h600, 1'b0, 64'h0);
        tick();
        drive_if(1'b0, 64'h0, 1'b0, 64'h0);
        drive_id(c_BEQ, 1'b0, 64'h640);
        #1;
        check_val("nt_flush", 64'(bus.flush_o),       64'h0);
        check_val("nt_updc",  64'(bus.upd_correct_o), 64'h1);
        check_val("nt_redir", bus.redirect_pc_o,      64'h0);
        check_val("nt_updt",  bus.upd_target_o,       64'h640);
        tick();

        // Fifth mispredict: mispredict counter stays saturated
        drive_if(1'b1, 64'h700, 1'b1, 64'h780);
        drive_id(c_ADD, 1'b0, 64'h0);
        tick();
        drive_if(1'b0, 64'h0, 1'b0, 64'h0);
        #1 check_val("sat_redir", bus.redirect_pc_o, 64'h704);
        tick();
        check_counts("sat", 3, 3);
        tick();

        // Asynchronous reset in the middle of a flush cycle
        drive_if(1'b1, 64'h800, 1'b1, 64'h880);
        tick();
        drive_if(1'b0, 64'h0, 1'b0, 64'h0);
        drive_id(c_BEQ, 1'b1, 64'h820);
        #1 check_val("ar_pre_flush", 64'(bus.flush_o), 64'h1);
        #2 arst_n = 1'b0;
        #1;
        check_val("ar_flush", 64'(bus.flush_o),     64'h0);
        check_val("ar_redir", bus.redirect_pc_o,    64'h0);
        check_val("ar_updv",  64'(bus.upd_valid_o), 64'h0);
        check_val("ar_updt",  bus.upd_target_o,     64'h0);
        check_counts("ar", 0, 0);
        tick();
        arst_n = 1'b1;
        #1 check_val("ar_release_flush", 64'(bus.flush_o), 64'h0);
        tick();
        check_val("ar_release_flush2", 64'(bus.flush_o), 64'h0);
        check_counts("ar_release", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
